k12a_acu_sliced: RTL
====================

// Module: k12a_acu_sliced
// PURPOSE
//  Parametrised, multi-cycle address computation unit for the K12a core. It adds a selected base
//  (PC, CD pair or SP) to a selected addend (+1, +2, -1, -2 or the scaled relative branch offset).
//  The add runs as a slice-serial adder, SLICE_WIDTH bits per clock, with a registered carry.
//  The committed result is driven onto the shared address bus under acu_load.
// PARAMETERS
//  ADDR_WIDTH   16  width of bases, result and addr_bus
//  SLICE_WIDTH  4   bits added per cycle; must divide ADDR_WIDTH; N = ADDR_WIDTH/SLICE_WIDTH
//  OFFSET_WIDTH 11  width of signed relative offset field; OFFSET_WIDTH+1 <= ADDR_WIDTH
// PORTS
//  clock       in    1             single clock; all state updates on rising edge
//  reset_n     in    1             synchronous, active-low reset
//  start       in    1             request a new computation; sampled only when accepted (see below)
//  base_sel    in    2             0=PC, 1={C,D}, 2=SP, 3=zero
//  addend_sel  in    3             0=+1, 1=+2, 2=-1 (all ones), 3=-2, 4=REL_OFFSET, 5-7=zero
//  pc          in    ADDR_WIDTH    program counter
//  c, d        in    ADDR_WIDTH/2  register pair, c is high half
//  sp          in    ADDR_WIDTH    stack pointer
//  rel_offset  in    OFFSET_WIDTH  signed instruction offset field
//  acu_load    in    1             drive committed result onto addr_bus
//  busy        out   1             computation in progress
//  done        out   1             one-cycle pulse: result committed this cycle
//  carry       out   1             carry out of MSB of last committed add
//  result      out   ADDR_WIDTH    last committed result
//  addr_bus    inout ADDR_WIDTH    result when acu_load=1, else high-Z
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, carry=0, result=0, and the internal
//    accumulator, operands and slice index are cleared. Reset wins over start. Reset mid-computation
//    aborts it; no done pulse is produced.
//  - REL_OFFSET addend = sign-extend(rel_offset) to ADDR_WIDTH-1 bits, then shift left by 1 (LSB 0).
//  - States are IDLE, RUN and DONE. start is accepted in IDLE or DONE; start in RUN is ignored,
//    is not queued and has no effect.
//  - Accept cycle: latch operand A = base and B = addend, set slice index 0 and carry_int 0. Go to RUN.
//    busy=1 from the next cycle.
//  - RUN, slice k: acc[k] = A[k] + B[k] + carry_int, where slice k is bits [k*SW +: SW]; the slice
//    carry goes into carry_int. After slice N-1, go to DONE.
//  - Latency: start accepted at edge T, so done=1 during the cycle after edge T+N. Example: SLICE_WIDTH=4,
//    ADDR_WIDTH=16 gives N=4.
//  - DONE lasts 1 cycle: done=1, busy=0, result=acc, carry=final carry. DONE then goes to IDLE, or
//    directly to RUN if start=1 in that cycle.
//  - result and carry change only on entry to DONE. During RUN they hold the previous committed
//    value, so partial sums are never visible.
//  - Arithmetic is modulo 2^ADDR_WIDTH: the MSB carry is dropped from result and reported on carry
//    (for example 0xFFFF + 1 gives 0x0000 with carry=1, and PC + (-1) with PC != 0 gives carry=1).
//  - Operand inputs may change freely after the accept cycle; they are not re-sampled.
//  - addr_bus is purely combinational from acu_load and result, independent of state. It may be
//    driven while busy, and then shows the previous committed result.
//  - SLICE_WIDTH=ADDR_WIDTH is legal: N=1 and done follows the accept edge by 1 cycle.
// TESTING
//  1. pc=0x1234, base=PC, addend=+1, start 1 cycle -> busy 4 cycles, done pulse, result=0x1235, carry=0
//  2. sp=0xFFFF, base=SP, addend=+1 -> result=0x0000, carry=1; addend=-2 on sp=0x0001 -> 0xFFFF, carry=0
//  3. c=0x80,d=0x00, addend=REL_OFFSET, rel_offset=0x7FF -> result=0x7FFE;
//     rel_offset=0x3FF on pc=0x0100 -> result=0x08FE
//  4. start held high through RUN -> exactly one computation per accept; back-to-back start in
//     DONE cycle -> second done exactly N+1 cycles after first
//  5. reset_n=0 at slice 2 of a run -> next cycle busy=0, done=0, result=0, carry=0; no later done pulse
//  6. acu_load=0 -> addr_bus=Z; acu_load=1 during RUN -> addr_bus=previous result;
//     N=1 build (SLICE_WIDTH=16) passes tests 1-3

Source files
------------

// File: rtl/k12a_acu_sliced.sv
// K12a address computation unit: base + addend computed as a slice-serial add,
// SLICE_WIDTH bits per clock, with a registered inter-slice carry.
module k12a_acu_sliced #(
  parameter int ADDR_WIDTH   = 16,
  parameter int SLICE_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 11
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                base_sel,
  input  logic [2:0]                addend_sel,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic [ADDR_WIDTH/2-1:0]   c,
  input  logic [ADDR_WIDTH/2-1:0]   d,
  input  logic [ADDR_WIDTH-1:0]     sp,
  input  logic [OFFSET_WIDTH-1:0]   rel_offset,
  input  logic                      acu_load,
  output logic                      busy,
  output logic                      done,
  output logic                      carry,
  output logic [ADDR_WIDTH-1:0]     result,
  inout  wire  [ADDR_WIDTH-1:0]     addr_bus
);

  localparam int N     = ADDR_WIDTH / SLICE_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_WIDTH-1:0] SL_MASK = ADDR_WIDTH'({SLICE_WIDTH{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_a;
  logic [ADDR_WIDTH-1:0]   r_b;
  logic [ADDR_WIDTH-1:0]   r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_cin;

  logic [ADDR_WIDTH-1:0]        w_base;
  logic [ADDR_WIDTH-1:0]        w_addend;
  logic signed [ADDR_WIDTH-1:0] w_rel_sx;
  logic [31:0]                  w_lsb;
  logic [SLICE_WIDTH-1:0]       w_a_sl;
  logic [SLICE_WIDTH-1:0]       w_b_sl;
  logic [SLICE_WIDTH:0]         w_sum;
  logic [ADDR_WIDTH-1:0]        w_acc_next;

  always_comb begin
    w_base = '0;
    case (base_sel)
      2'd0:    w_base = pc;
      2'd1:    w_base = {c, d};
      2'd2:    w_base = sp;
      default: w_base = '0;
    endcase
  end

  // Branch offsets are halfword-scaled: sign-extend, then shift in a zero LSB.
  assign w_rel_sx = ADDR_WIDTH'($signed(rel_offset));

  always_comb begin
    w_addend = '0;
    case (addend_sel)
      3'd0:    w_addend = ADDR_WIDTH'(1);
      3'd1:    w_addend = ADDR_WIDTH'(2);
      3'd2:    w_addend = '1;
      3'd3:    w_addend = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
      3'd4:    w_addend = {w_rel_sx[ADDR_WIDTH-2:0], 1'b0};
      default: w_addend = '0;
    endcase
  end

  assign w_lsb  = 32'(r_idx) * SLICE_WIDTH;
  assign w_a_sl = SLICE_WIDTH'(r_a >> w_lsb);
  assign w_b_sl = SLICE_WIDTH'(r_b >> w_lsb);
  assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE_WIDTH+1)'(r_cin);

  // Merge the current slice into the accumulator without disturbing the others.
  assign w_acc_next = (r_acc & ~(SL_MASK << w_lsb))
                    | (ADDR_WIDTH'(w_sum[SLICE_WIDTH-1:0]) << w_lsb);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      carry   <= 1'b0;
      result  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_cin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= w_base;
            r_b     <= w_addend;
            r_idx   <= '0;
            r_cin   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cin <= w_sum[SLICE_WIDTH];
          // Commit only on the last slice so partial sums never reach result.
          if (r_idx == IDX_W'(N-1)) begin
            result  <= w_acc_next;
            carry   <= w_sum[SLICE_WIDTH];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_bus = acu_load ? result : {ADDR_WIDTH{1'bz}};

endmodule
